// File: rtl/itlb_ptw.sv
// Two-level page-table walker servicing ITLB misses over a req/valid memory port.
// Optional superpage (leaf at level 1) support is enabled by defining ITLB_PTW_SUPERPAGE_EN.
module itlb_ptw #(
  parameter int VA_WIDTH   = 32,
  parameter int PA_WIDTH   = 32,
  parameter int PPN_WIDTH  = 20,
  parameter int VPN1_WIDTH = 10,
  parameter int VPN0_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ptw_req,
  input  logic [VA_WIDTH-1:0]  ptw_va,
  input  logic [PPN_WIDTH-1:0] ptbr,
  output logic                 ptw_valid,
  output logic [PPN_WIDTH-1:0] ptw_pa,
  output logic                 ptw_fault,
  output logic                 ptw_busy,
  output logic                 mem_req,
  output logic [PA_WIDTH-1:0]  mem_addr,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                  state_q;
  logic [VPN0_WIDTH-1:0]   vpn0_q;

  logic                    pte_v;
  logic [PPN_WIDTH-1:0]    pte_ppn;
  logic [VPN1_WIDTH-1:0]   va_vpn1;
  logic [VPN0_WIDTH-1:0]   va_vpn0;
  logic                    unused_bits;

  assign pte_v   = mem_rdata[0];
  assign pte_ppn = mem_rdata[31 -: PPN_WIDTH];
  assign va_vpn1 = ptw_va[VA_WIDTH-1 -: VPN1_WIDTH];
  assign va_vpn0 = ptw_va[VA_WIDTH-VPN1_WIDTH-1 -: VPN0_WIDTH];
  assign unused_bits = ^{mem_rdata[11:1], ptw_va[VA_WIDTH-VPN1_WIDTH-VPN0_WIDTH-1:0]};

  // The level-1 address is formed at acceptance, so root/vpn1 never need a separate copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vpn0_q    <= '0;
      ptw_valid <= 1'b0;
      ptw_pa    <= '0;
      ptw_fault <= 1'b0;
      ptw_busy  <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      ptw_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ptw_req) begin
            state_q   <= S_L1;
            vpn0_q    <= va_vpn0;
            ptw_busy  <= 1'b1;
            mem_req   <= 1'b1;
            mem_addr  <= {ptbr, va_vpn1, 2'b00};
            ptw_pa    <= '0;
            ptw_fault <= 1'b0;
          end
        end
        S_L1: begin
          if (mem_valid) begin
            if (!pte_v) begin
              state_q   <= S_RESP;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              ptw_valid <= 1'b1;
              ptw_fault <= 1'b1;
              ptw_pa    <= '0;
`ifdef ITLB_PTW_SUPERPAGE_EN
            end else if (mem_rdata[1]) begin
              // Superpage leaf: the low VPN passes straight through as the low PPN.
              state_q   <= S_RESP;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              ptw_valid <= 1'b1;
              ptw_fault <= 1'b0;
              ptw_pa    <= {mem_rdata[31 -: PPN_WIDTH-VPN0_WIDTH], vpn0_q};
`endif
            end else begin
              state_q  <= S_L2;
              mem_addr <= {pte_ppn, vpn0_q, 2'b00};
            end
          end
        end
        S_L2: begin
          if (mem_valid) begin
            state_q   <= S_RESP;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            ptw_valid <= 1'b1;
            ptw_fault <= ~pte_v;
            ptw_pa    <= pte_v ? pte_ppn : '0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          ptw_busy  <= 1'b0;
          ptw_fault <= 1'b0;
          ptw_pa    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itlb_ptw.sv
// Directed bench for itlb_ptw: a spec-level expectation set per cycle, checked on every falling edge.
module tb_itlb_ptw;

  logic        clk = 1'b0;
  logic        rst, ptw_req, mem_valid;
  logic [31:0] ptw_va, mem_rdata;
  logic [19:0] ptbr;
  logic        ptw_valid, ptw_fault, ptw_busy, mem_req;
  logic [19:0] ptw_pa;
  logic [31:0] mem_addr;

  always #5 clk = ~clk;

  itlb_ptw dut (
    .clk(clk), .rst(rst), .ptw_req(ptw_req), .ptw_va(ptw_va), .ptbr(ptbr),
    .ptw_valid(ptw_valid), .ptw_pa(ptw_pa), .ptw_fault(ptw_fault), .ptw_busy(ptw_busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, maintained by the stimulus from the walk rules.
  logic        exp_valid, exp_fault, exp_busy, exp_req;
  logic [19:0] exp_pa;
  logic [31:0] exp_addr;

  // Observations captured during a walk for the literal checks.
  int          n_hs, n_resp;
  logic [31:0] cap_addr [4];
  logic [19:0] cap_pa;
  logic        cap_fault;

  always @(negedge clk) begin
    checks++;
    if ({ptw_valid, ptw_fault, ptw_busy, mem_req, ptw_pa, mem_addr} !==
        {exp_valid, exp_fault, exp_busy, exp_req, exp_pa, exp_addr}) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: valid/fault/busy/req=%b%b%b%b pa=%h addr=%h, required %b%b%b%b pa=%h addr=%h",
               $time, ptw_valid, ptw_fault, ptw_busy, mem_req, ptw_pa, mem_addr,
               exp_valid, exp_fault, exp_busy, exp_req, exp_pa, exp_addr);
    end
    if (mem_req && mem_valid && n_hs < 4) begin
      cap_addr[n_hs] = mem_addr;
      n_hs++;
    end
    if (ptw_valid) begin
      cap_pa    = ptw_pa;
      cap_fault = ptw_fault;
      n_resp++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    exp_valid = 1'b0; exp_fault = 1'b0; exp_busy = 1'b0; exp_req = 1'b0;
    exp_pa = '0; exp_addr = '0;
  endtask

  task automatic walk(input logic [31:0] va, input logic [19:0] root,
                      input logic [31:0] pte1, input logic [31:0] pte2,
                      input int w1, input int w2, input bit chg_inputs);
    logic [31:0] a1, a2;
    logic        leaf;
    a1   = {root, va[31:22], 2'b00};
    a2   = {pte1[31:12], va[21:12], 2'b00};
    leaf = 1'b0;
`ifdef ITLB_PTW_SUPERPAGE_EN
    leaf = pte1[1];
`endif
    n_hs = 0; n_resp = 0;
    ptw_req = 1'b1; ptw_va = va; ptbr = root;
    step;
    ptw_req = 1'b0;
    exp_busy = 1'b1; exp_req = 1'b1; exp_addr = a1;
    if (chg_inputs) begin
      ptw_va = 32'hFFFFF000;
      ptbr   = 20'hFFFFF;
    end
    repeat (w1) step;
    mem_valid = 1'b1; mem_rdata = pte1;
    step;
    mem_valid = 1'b0; mem_rdata = $urandom;
    if (!pte1[0] || leaf) begin
      exp_req = 1'b0; exp_addr = '0; exp_valid = 1'b1;
      exp_fault = ~pte1[0];
      exp_pa = pte1[0] ? {pte1[31:22], va[21:12]} : 20'h0;
    end else begin
      exp_addr = a2;
      repeat (w2) step;
      mem_valid = 1'b1; mem_rdata = pte2;
      step;
      mem_valid = 1'b0; mem_rdata = $urandom;
      exp_req = 1'b0; exp_addr = '0; exp_valid = 1'b1;
      exp_fault = ~pte2[0];
      exp_pa = pte2[0] ? pte2[31:12] : 20'h0;
    end
    step;
    set_idle;
    step;
  endtask

  initial begin
    rst = 1'b1; ptw_req = 1'b0; ptw_va = '0; ptbr = '0;
    mem_valid = 1'b0; mem_rdata = '0;
    n_hs = 0; n_resp = 0;
    set_idle;
    step; step;
    check("reset_ctrl", {28'h0, ptw_valid, ptw_fault, ptw_busy, mem_req}, 32'h0);
    check("reset_pa", ptw_pa, 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    rst = 1'b0;
    step;

    // Basic two-level walk.
    walk(32'h00403ABC, 20'h00100, 32'h00200001, 32'h12345001, 0, 0, 1'b0);
    check("basic_l1_addr", cap_addr[0], 32'h00100004);
    check("basic_l2_addr", cap_addr[1], 32'h0020000C);
    check("basic_pa", cap_pa, 32'h12345);
    check("basic_fault", cap_fault, 32'h0);
    check("basic_resp_count", n_resp, 32'd1);

    // Level-1 invalid PTE.
    walk(32'h00403ABC, 20'h00100, 32'h00200000, 32'h12345001, 0, 0, 1'b0);
    check("l1fault_hs_count", n_hs, 32'd1);
    check("l1fault_fault", cap_fault, 32'h1);
    check("l1fault_pa", cap_pa, 32'h0);

    // Level-2 invalid PTE.
    walk(32'h00403ABC, 20'h00100, 32'h00200001, 32'h77777000, 1, 2, 1'b0);
    check("l2fault_fault", cap_fault, 32'h1);
    check("l2fault_pa", cap_pa, 32'h0);

    // Memory wait states at both levels.
    walk(32'h00403ABC, 20'h00100, 32'h00200001, 32'h12345001, 5, 5, 1'b0);
    check("wait_pa", cap_pa, 32'h12345);

    // Spurious memory response while idle, then inputs changed during L1.
    mem_valid = 1'b1; mem_rdata = 32'h00200001;
    step; step;
    mem_valid = 1'b0;
    step;
    walk(32'h00403ABC, 20'h00100, 32'h00200001, 32'h12345001, 2, 0, 1'b1);
    check("stable_l1_addr", cap_addr[0], 32'h00100004);
    check("stable_l2_addr", cap_addr[1], 32'h0020000C);

    // All-ones indices.
    walk(32'hFFC01000, 20'hFFFFF, 32'hFFFFF001, 32'hA5A5A001, 0, 1, 1'b0);
    check("ones_l1_addr", cap_addr[0], 32'hFFFFFFFC);
    check("ones_l2_addr", cap_addr[1], 32'hFFFFF004);
    check("ones_pa", cap_pa, 32'hA5A5A);

    // Reset asserted while waiting in L2.
    n_hs = 0; n_resp = 0;
    ptw_req = 1'b1; ptw_va = 32'h00403ABC; ptbr = 20'h00100;
    step;
    ptw_req = 1'b0;
    exp_busy = 1'b1; exp_req = 1'b1; exp_addr = 32'h00100004;
    mem_valid = 1'b1; mem_rdata = 32'h00200001;
    step;
    mem_valid = 1'b0;
    exp_addr = 32'h0020000C;
    step;
    #2;
    rst = 1'b1;
    set_idle;
    #1;
    check("rst_async_ctrl", {28'h0, ptw_valid, ptw_fault, ptw_busy, mem_req}, 32'h0);
    check("rst_async_addr", mem_addr, 32'h0);
    check("rst_async_pa", ptw_pa, 32'h0);
    step;
    rst = 1'b0;
    mem_valid = 1'b1; mem_rdata = 32'h12345001;
    step;
    mem_valid = 1'b0;
    step;
    check("rst_late_resp_ignored", n_resp, 32'd0);
    walk(32'h00403ABC, 20'h00100, 32'h00200001, 32'h12345001, 0, 0, 1'b0);
    check("post_rst_l1_addr", cap_addr[0], 32'h00100004);
    check("post_rst_pa", cap_pa, 32'h12345);

    // Leaf bit set at level 1.
    walk(32'h00403ABC, 20'h00100, 32'hABC00003, 32'h55555001, 0, 0, 1'b0);
`ifdef ITLB_PTW_SUPERPAGE_EN
    check("super_hs_count", n_hs, 32'd1);
    check("super_pa", cap_pa, 32'hABC03);
    check("super_fault", cap_fault, 32'h0);
`else
    check("noleaf_hs_count", n_hs, 32'd2);
    check("noleaf_l2_addr", cap_addr[1], 32'hABC0000C);
    check("noleaf_pa", cap_pa, 32'h55555);
`endif

    // Leaf bit with V clear is still a fault.
    walk(32'h00403ABC, 20'h00100, 32'hABC00002, 32'h55555001, 0, 0, 1'b0);
    check("leaf_invalid_fault", cap_fault, 32'h1);
    check("leaf_invalid_pa", cap_pa, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/itlb_ptw.md
Name: itlb_ptw

Overview:
- Two-level hardware page-table walker that services ITLB misses.
- Accepts a miss VA from the ITLB and reads two 32-bit PTEs from memory through a req/valid memory port.
- Returns a 20-bit PPN to the ITLB, pulsing valid for one cycle; the ITLB refills its entry on that pulse.
- Sits directly downstream of the ITLB and upstream of the memory arbiter.

Parameters:
- VA_WIDTH, 32, virtual address width
- PA_WIDTH, 32, physical/memory address width
- PPN_WIDTH, 20, physical page number width
- VPN1_WIDTH, 10, level-1 index width (VA[31:22])
- VPN0_WIDTH, 10, level-0 index width (VA[21:12])

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- ptw_req  in  1  ITLB miss request; level, held until served
- ptw_va  in  VA_WIDTH  VA to translate; sampled only on acceptance
- ptbr  in  PPN_WIDTH  root page-table PPN; sampled on acceptance
- ptw_valid  out  1  one-cycle pulse: translation (or fault) ready
- ptw_pa  out  PPN_WIDTH  translated PPN; valid only while ptw_valid=1
- ptw_fault  out  1  qualifies ptw_valid: walk hit an invalid PTE
- ptw_busy  out  1  high in any state other than IDLE
- mem_req  out  1  memory read request; level, held until mem_valid
- mem_addr  out  PA_WIDTH  word address of the PTE being read
- mem_valid  in  1  one-cycle pulse: mem_rdata valid
- mem_rdata  in  32  PTE data

Behaviour:
- PTE format:
  - bit0 V (valid)
  - bit1 L (leaf; used only by the optional feature)
  - bits[31:12] PPN
  - other bits ignored
- States: IDLE, L1, L2, RESP.
- IDLE:
  - If ptw_req=1, latch vpn1=ptw_va[31:22], vpn0=ptw_va[21:12] and root=ptbr, then go to L1.
  - Otherwise stay in IDLE.
- L1:
  - mem_req=1, mem_addr={root, vpn1, 2'b00}.
  - On mem_valid: if rdata[0]=0, set fault=1 and go to RESP; else latch ppn1=rdata[31:12] and go to L2.
- L2:
  - mem_req=1, mem_addr={ppn1, vpn0, 2'b00}.
  - On mem_valid: if rdata[0]=0, set fault=1; else latch result=rdata[31:12]. Go to RESP.
- RESP:
  - ptw_valid=1 for exactly one cycle.
  - ptw_pa=result, or 0 on fault; ptw_fault=fault.
  - Next state is IDLE unconditionally; ptw_req is ignored in RESP.
- Latency:
  - mem_req rises 1 cycle after acceptance.
  - ptw_valid rises 1 cycle after the final mem_valid.
  - Minimum total, with zero-wait memory: accept → L1 → L2 → RESP, i.e. 3 cycles after acceptance.
- Address arithmetic: pure concatenation, no adders. The width must satisfy PPN_WIDTH+VPN1_WIDTH+2 = PA_WIDTH.
- mem_addr is 0 in IDLE and RESP. mem_req is registered and changes only on state transitions.
- mem_valid in IDLE or RESP (spurious) is ignored and causes no state change.
- ptw_va and ptbr changes after acceptance do not affect the walk in progress.
- ptw_req dropping mid-walk does not abort the walk; it completes and still pulses ptw_valid.
- rst, asynchronous and at any time including mid-walk:
  - State goes to IDLE.
  - ptw_valid, ptw_fault, ptw_busy and mem_req go to 0.
  - mem_addr and ptw_pa go to 0.
  - All latched registers are cleared.
  - An outstanding memory response after reset is ignored.
- Consumer contract: the ITLB must not install an entry when ptw_fault=1. ptw_pa=0 in that case.

Optional Feature:
- Macro: ITLB_PTW_SUPERPAGE_EN.
- Defined, superpage support: at L1, if V=1 and L=1, skip L2 and go to RESP with result={rdata[31:22], vpn0} and fault=0.
- Undefined: the L bit is ignored and L1 always proceeds to L2 when V=1.

Test Plan:
- Basic walk: ptbr=0x00100, ptw_va=0x00403ABC, ptw_req=1.
  - mem_addr=0x00100004, rdata=0x00200001.
  - Then mem_addr=0x0020000C, rdata=0x12345001.
  - Result: ptw_valid 1-cycle pulse, ptw_pa=0x12345, ptw_fault=0, back to IDLE.
- L1 fault: same VA, L1 rdata=0x00200000.
  - No L2 request is issued.
  - ptw_valid=1, ptw_fault=1, ptw_pa=0.
- Memory wait states: mem_valid delayed 5 cycles at each level.
  - mem_req stays 1 and mem_addr stays stable throughout.
  - ptw_valid occurs exactly 1 cycle after the second mem_valid.
- Input stability and spurious response: change ptw_va to 0xFFFFF000 during L1, and pulse mem_valid in IDLE.
  - The walk still uses 0x00403ABC.
  - The spurious pulse causes no transition.
- Reset mid-walk: assert rst during L2.
  - All outputs are 0 immediately.
  - A later mem_valid is ignored.
  - A new ptw_req after release starts a fresh walk at L1.
- Superpage (macro defined): L1 rdata=0xABC00003, vpn0=0x003.
  - No L2 request; ptw_pa=0xABC03.
  - With the macro undefined, an L2 request is issued to {0xABC00, 10'h003, 2'b00} = 0xABC0000C.
